// File: rtl/fifo_buffer_if.sv
// Request/status bundle between the enable organiser and the FIFO.
// master drives requests and write data; slave returns read data and flags.
interface fifo_buffer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              synchr_enable_write;
    logic              synchr_enable_read;
    logic [DATA_W-1:0] synchr_to_write;
    logic [DATA_W-1:0] read_value;
    logic              read_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output synchr_enable_write,
        output synchr_enable_read,
        output synchr_to_write,
        input  read_value,
        input  read_valid,
        input  full,
        input  empty,
        input  count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  synchr_enable_write,
        input  synchr_enable_read,
        input  synchr_to_write,
        output read_value,
        output read_valid,
        output full,
        output empty,
        output count,
        output overflow,
        output underflow
    );
endinterface

// File: rtl/fifo_buffer.sv
// Synchronous FIFO, DEPTH = 2^ADDR_W words, registered data and flags.
// Requests are single-cycle pulses already synchronous to clk.
module fifo_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input logic          clk,
    input logic          rst,
    fifo_buffer_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, full_q, empty_q;
    logic              ovf_q, unf_q;
    logic              rd_acc, wr_acc;

    // A full FIFO may still take a write when a read frees a slot.
    assign rd_acc = bus.synchr_enable_read & ~empty_q;
    assign wr_acc = bus.synchr_enable_write & (~full_q | rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rdata_d  = rdata_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rdata_d  = mem_q[rd_ptr_q];
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rd_acc;
            full_q   <= (count_d == DEPTH_C);
            empty_q  <= (count_d == '0);
            ovf_q    <= bus.synchr_enable_write & ~wr_acc;
            unf_q    <= bus.synchr_enable_read & ~rd_acc;
        end
    end

    // Storage is not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (rst && wr_acc) begin
            mem_q[wr_ptr_q] <= bus.synchr_to_write;
        end
    end

    assign bus.read_value = rdata_q;
    assign bus.read_valid = rvalid_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
    assign bus.count      = count_q;
    assign bus.overflow   = ovf_q;
    assign bus.underflow  = unf_q;
endmodule

// File: tb/tb_fifo_buffer.sv
// Bench for fifo_buffer: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_fifo_buffer;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass = 0;
    int   n_chk  = 0;

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_rv = '0;
    logic              m_rvld = 1'b0;
    logic              m_ovf = 1'b0;
    logic              m_unf = 1'b0;

    fifo_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    fifo_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic we, input logic re,
                        input logic [DATA_W-1:0] d, input logic rn);
        bit racc, wacc;
        bus.synchr_enable_write = we;
        bus.synchr_enable_read  = re;
        bus.synchr_to_write     = d;
        rst                     = rn;
        @(posedge clk);
        if (!rn) begin
            q.delete();
            m_rv   = '0;
            m_rvld = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            racc = re && (q.size() > 0);
            wacc = we && ((q.size() < DEPTH) || racc);
            if (racc) m_rv = q.pop_front();
            if (wacc) q.push_back(d);
            m_rvld = racc;
            m_ovf  = we && !wacc;
            m_unf  = re && !racc;
        end
        #1;
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("empty", 32'(bus.empty), 32'(q.size() == 0));
        chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
        chk("read_value", 32'(bus.read_value), 32'(m_rv));
        chk("read_valid", 32'(bus.read_valid), 32'(m_rvld));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("underflow", 32'(bus.underflow), 32'(m_unf));
    endtask

    initial begin
        bus.synchr_enable_write = 1'b0;
        bus.synchr_enable_read  = 1'b0;
        bus.synchr_to_write     = '0;

        // Reset, including a concurrent request that must be ignored.
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_count", 32'(bus.count), 32'd0);

        // Single write then read.
        step(1'b1, 1'b0, 8'h07, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        chk("rd07_value", 32'(bus.read_value), 32'h07);
        chk("rd07_valid", 32'(bus.read_valid), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("rd07_pulse", 32'(bus.read_valid), 32'd0);

        // Fill, overflow, drain, then underflow.
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'(i), 1'b1);
        chk("fill_full", 32'(bus.full), 32'd1);
        step(1'b1, 1'b0, 8'h05, 1'b1);
        chk("ovf_pulse", 32'(bus.overflow), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("ovf_clear", 32'(bus.overflow), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b1);
            chk("drain", 32'(bus.read_value), 32'(i));
        end
        step(1'b0, 1'b1, 8'h00, 1'b1);
        chk("unf_pulse", 32'(bus.underflow), 32'd1);
        chk("unf_hold", 32'(bus.read_value), 32'h04);

        // Full with simultaneous read+write.
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'(i), 1'b1);
        step(1'b1, 1'b1, 8'h05, 1'b1);
        chk("rw_full_val", 32'(bus.read_value), 32'h01);
        chk("rw_full_ovf", 32'(bus.overflow), 32'd0);
        chk("rw_full_cnt", 32'(bus.count), 32'd4);
        for (int i = 2; i <= 5; i++) step(1'b0, 1'b1, 8'h00, 1'b1);
        chk("rw_full_last", 32'(bus.read_value), 32'h05);

        // Empty with simultaneous read+write: no bypass.
        step(1'b1, 1'b1, 8'hAA, 1'b1);
        chk("rw_empty_unf", 32'(bus.underflow), 32'd1);
        chk("rw_empty_cnt", 32'(bus.count), 32'd1);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        chk("rw_empty_val", 32'(bus.read_value), 32'hAA);

        // Mid-operation reset discards contents.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h30 + i), 1'b1);
        step(1'b1, 1'b0, 8'h99, 1'b0);
        chk("mid_rst_cnt", 32'(bus.count), 32'd0);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        chk("mid_rst_unf", 32'(bus.underflow), 32'd1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 99) < 55),
                 1'($urandom_range(0, 99) < 50),
                 8'($urandom),
                 1'($urandom_range(0, 199) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
